// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmitter. A parallel byte is turned into a serial frame on TX_OUT:
// one start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity
// bit, and one stop bit (1). Every bit lasts PRESCALE clocks. PRESCALE is the
// same clocks-per-bit value that the receive side uses.
//
// Build option:
//   UART_TX_PARITY_EN defined   - PAR_EN / PAR_TYP are used, and the PARITY
//                                 state and the parity logic are built.
//   UART_TX_PARITY_EN undefined - PAR_EN / PAR_TYP are still ports but are
//                                 ignored. DATA always goes straight to STOP.
//
// Ports:
//   CLK         in   system clock, all logic on the rising edge
//   RST         in   synchronous reset, active high
//   P_DATA      in   payload, sampled together with DATA_VALID
//   DATA_VALID  in   send request, accepted only while BUSY=0
//   PAR_EN      in   1 = add a parity bit (needs UART_TX_PARITY_EN)
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   PRESCALE    in   clocks per serial bit; values below 4 are raised to 4
//   TX_OUT      out  serial line, registered, high when idle
//   BUSY        out  high while a frame is on the line, registered
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0]      LAST_BIT     = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] MIN_PRESCALE = PRESCALE_WIDTH'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                      state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0]   edge_cnt_reg, edge_cnt_next;
  logic [BIT_CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]       data_reg, data_next;
  logic [PRESCALE_WIDTH-1:0]   prescale_reg, prescale_next;
  logic                        tx_out_reg, tx_out_next;
  logic                        busy_reg, busy_next;
  logic                        last_edge;

`ifdef UART_TX_PARITY_EN
  logic par_en_reg, par_en_next;
  logic par_typ_reg, par_typ_next;
`else
  // Without parity support these ports have no function. This signal
  // connects them to something so that lint does not flag them.
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // A bit ends on the last clock of its PRESCALE-long slot.
  assign last_edge = (edge_cnt_reg == (prescale_reg - PRESCALE_WIDTH'(1)));

  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    prescale_next = prescale_reg;
`ifdef UART_TX_PARITY_EN
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;
`endif
    tx_out_next   = 1'b1;
    busy_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (DATA_VALID) begin
          // Capture everything now, so input changes during the frame do not affect it.
          data_next     = P_DATA;
          prescale_next = (PRESCALE < MIN_PRESCALE) ? MIN_PRESCALE : PRESCALE;
`ifdef UART_TX_PARITY_EN
          par_en_next   = PAR_EN;
          par_typ_next  = PAR_TYP;
`endif
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_START;
        end
      end

      ST_START: begin
        if (last_edge) begin
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_DATA;
        end else begin
          edge_cnt_next = edge_cnt_reg + PRESCALE_WIDTH'(1);
        end
      end

      ST_DATA: begin
        if (last_edge) begin
          edge_cnt_next = '0;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = par_en_reg ? ST_PARITY : ST_STOP;
`else
            state_next   = ST_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          end
        end else begin
          edge_cnt_next = edge_cnt_reg + PRESCALE_WIDTH'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (last_edge) begin
          edge_cnt_next = '0;
          state_next    = ST_STOP;
        end else begin
          edge_cnt_next = edge_cnt_reg + PRESCALE_WIDTH'(1);
        end
      end
`endif

      ST_STOP: begin
        if (last_edge) begin
          edge_cnt_next = '0;
          state_next    = ST_IDLE;
        end else begin
          edge_cnt_next = edge_cnt_reg + PRESCALE_WIDTH'(1);
        end
      end

      default: begin
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        state_next    = ST_IDLE;
      end
    endcase

    // The line level is computed from the next state. This lets TX_OUT come
    // from a flop and still change on the same edge as the state.
    case (state_next)
      ST_START:  tx_out_next = 1'b0;
      ST_DATA:   tx_out_next = data_next[bit_cnt_next];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_out_next = (^data_next) ^ par_typ_next;
`endif
      default:   tx_out_next = 1'b1;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      prescale_reg <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
`endif
      tx_out_reg   <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      prescale_reg <= prescale_next;
`ifdef UART_TX_PARITY_EN
      par_en_reg   <= par_en_next;
      par_typ_reg  <= par_typ_next;
`endif
      tx_out_reg   <= tx_out_next;
      busy_reg     <= busy_next;
    end
  end

  assign TX_OUT = tx_out_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Directed testbench for uart_tx_frame. Each frame is compared with a bit
// sequence that is worked out by hand. TX_OUT and BUSY are checked on every
// clock of the frame and again on the idle clock that follows it.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       BUSY;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_frame #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .PRESCALE  (PRESCALE),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one frame and checks every clock of it, then the idle clock after it.
  //   p_eff      - expected clocks per bit (after the clamp to 4)
  //   with_par   - a parity bit is expected on the line
  //   par_bit    - expected value of the parity bit
  //   hold_valid - keep DATA_VALID high after acceptance (back-to-back frames)
  //   glitch_cyc - frame clock on which a second request with other inputs is
  //                pulsed (-1 = none)
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [5:0] ps_in,
                           input int p_eff, input bit with_par, input bit par_bit,
                           input bit hold_valid, input int glitch_cyc);
    logic exp_bits [0:10];
    int   nbits;
    int   cyc;
    logic saved_par_en;
    saved_par_en = PAR_EN;
    nbits = with_par ? 11 : 10;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
    if (with_par) exp_bits[9] = par_bit;
    exp_bits[nbits-1] = 1'b1;

    P_DATA     = d;
    PRESCALE   = ps_in;
    DATA_VALID = 1'b1;
    tick();
    if (!hold_valid) DATA_VALID = 1'b0;

    cyc = 0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < p_eff; c++) begin
        check_eq($sformatf("%s bit%0d clk%0d tx", tag, k, c), TX_OUT, exp_bits[k]);
        check_eq($sformatf("%s bit%0d clk%0d busy", tag, k, c), BUSY, 1);
        if (cyc == glitch_cyc) begin
          P_DATA     = 8'h3C;
          PRESCALE   = 6'd5;
          PAR_EN     = ~saved_par_en;
          DATA_VALID = 1'b1;
        end else if (cyc == glitch_cyc + 1) begin
          DATA_VALID = 1'b0;
          PAR_EN     = saved_par_en;
        end
        cyc++;
        tick();
      end
    end
    check_eq($sformatf("%s idle tx", tag), TX_OUT, 1);
    check_eq($sformatf("%s idle busy", tag), BUSY, 0);
    $display("frame %s: data=%02h prescale_in=%0d clocks/bit=%0d bits=%0d", tag, d, ps_in, p_eff, nbits);
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    PRESCALE   = 6'd8;
    tick();
    tick();
    check_eq("reset tx", TX_OUT, 1);
    check_eq("reset busy", BUSY, 0);
    RST = 1'b0;
    tick();
    check_eq("post-reset idle tx", TX_OUT, 1);
    check_eq("post-reset idle busy", BUSY, 0);

    // Basic frame: line bits 0,1,0,1,0,0,1,0,1,1, 8 clocks each.
    run_frame("a5_p8", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, -1);

    // Parity. 8'hA5 has four ones, so even parity is 0 and odd parity is 1.
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
`ifdef UART_TX_PARITY_EN
    run_frame("a5_even", 8'hA5, 6'd8, 8, 1'b1, 1'b0, 1'b0, -1);
    PAR_TYP = 1'b1;
    run_frame("a5_odd", 8'hA5, 6'd8, 8, 1'b1, 1'b1, 1'b0, -1);
`else
    run_frame("a5_paren_ignored", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, -1);
    PAR_TYP = 1'b1;
    run_frame("a5_partyp_ignored", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, -1);
`endif
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;

    // A request for 8'h3C made during the 8'hA5 frame must be ignored.
    run_frame("a5_glitch3c", 8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b0, 20);
    check_eq("after glitch stays idle tx", TX_OUT, 1);
    tick();
    check_eq("after glitch stays idle busy", BUSY, 0);

    // DATA_VALID held high: exactly one idle clock between the two frames.
    run_frame("55_b2b_first", 8'h55, 6'd4, 4, 1'b0, 1'b0, 1'b1, -1);
    run_frame("55_b2b_second", 8'h55, 6'd4, 4, 1'b0, 1'b0, 1'b0, -1);

    // Reset during data bit 3.
    P_DATA     = 8'hA5;
    PRESCALE   = 6'd8;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    repeat (34) tick();
    check_eq("mid bit3 tx", TX_OUT, 0);
    check_eq("mid bit3 busy", BUSY, 1);
    RST = 1'b1;
    tick();
    check_eq("mid-frame reset tx", TX_OUT, 1);
    check_eq("mid-frame reset busy", BUSY, 0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("no resume clk%0d tx", i), TX_OUT, 1);
      check_eq($sformatf("no resume clk%0d busy", i), BUSY, 0);
    end
    $display("frame reset_mid_bit3: data=a5 abandoned");
    run_frame("3c_after_reset", 8'h3C, 6'd8, 8, 1'b0, 1'b0, 1'b0, -1);

    // Values below 4 are raised to 4. Also test the largest legal PRESCALE.
    run_frame("c3_clamp2", 8'hC3, 6'd2, 4, 1'b0, 1'b0, 1'b0, -1);
    run_frame("81_clamp0", 8'h81, 6'd0, 4, 1'b0, 1'b0, 1'b0, -1);
    run_frame("0f_p63", 8'h0F, 6'd63, 63, 1'b0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
